// File: rtl/clock_enable_scheduler.sv
// Group-controlled clock-enable scheduler: NCHAN down-counters emit single-cycle tick strobes on clk.
// Optional CLKSCHED_PHASE_EN adds a per-channel square-wave phase output toggled by each raw tick.
module clock_enable_scheduler #(
  parameter int NCHAN = 4,
  parameter int DIVW  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic [NCHAN-1:0]         chan_en,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [$clog2(NCHAN)-1:0] cfg_chan,
  input  logic [DIVW-1:0]          cfg_div,
  output logic                     running,
  output logic [NCHAN-1:0]         tick
`ifdef CLKSCHED_PHASE_EN
  ,
  output logic [NCHAN-1:0]         phase
`endif
);

  // state | meaning
  // IDLE  | counters parked, config writes go straight to div_act
  // ALIGN | counters loaded from div_act, phase cleared
  // RUN   | counters active, config writes staged through div_shd
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int CW = $clog2(NCHAN);
  localparam logic [CW:0] NCHAN_W = (CW + 1)'(NCHAN);

  state_t state, state_next;

  logic [NCHAN-1:0] tick_q;
  logic [DIVW-1:0]  div_act [NCHAN];
  logic [DIVW-1:0]  div_shd [NCHAN];
  logic [DIVW-1:0]  cnt     [NCHAN];
  logic             pend;
  logic [CW-1:0]    pend_chan;

  logic in_run;
  logic leave_run;
  logic chan_ok;
  logic cfg_acc;
  logic pend_xfer;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ALIGN;
      ALIGN:   state_next = stop ? IDLE : RUN;
      RUN:     if (stop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == RUN);
    end
  end

  assign in_run    = (state == RUN);
  assign leave_run = in_run & stop;
  assign chan_ok   = ({1'b0, cfg_chan} < NCHAN_W);
  assign cfg_ready = ~pend;
  assign cfg_acc   = cfg_valid & ~pend & chan_ok;
  // A staged value lands either at its channel's reload or when RUN is abandoned.
  assign pend_xfer = pend & in_run & (stop | (cnt[pend_chan] == '0));

  assign tick = tick_q & chan_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q    <= '0;
      pend      <= 1'b0;
      pend_chan <= '0;
`ifdef CLKSCHED_PHASE_EN
      phase     <= '0;
`endif
      for (int i = 0; i < NCHAN; i++) begin
        cnt[i]     <= '0;
        div_act[i] <= '0;
        div_shd[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCHAN; i++) begin
        case (state)
          ALIGN: begin
            cnt[i]    <= div_act[i];
            tick_q[i] <= 1'b0;
`ifdef CLKSCHED_PHASE_EN
            phase[i]  <= 1'b0;
`endif
          end
          RUN: begin
            if (stop) begin
              tick_q[i] <= 1'b0;
            end else if (cnt[i] == '0) begin
              tick_q[i] <= 1'b1;
              cnt[i]    <= (pend && (pend_chan == CW'(i))) ? div_shd[i] : div_act[i];
`ifdef CLKSCHED_PHASE_EN
              phase[i]  <= ~phase[i];
`endif
            end else begin
              tick_q[i] <= 1'b0;
              cnt[i]    <= cnt[i] - DIVW'(1);
            end
          end
          default: tick_q[i] <= 1'b0;
        endcase
      end

      if (pend_xfer) begin
        div_act[pend_chan] <= div_shd[pend_chan];
        pend               <= 1'b0;
      end

      // cfg_acc implies pend is clear, so this never collides with the transfer above.
      if (cfg_acc) begin
        if (!in_run || stop) begin
          div_act[cfg_chan] <= cfg_div;
          div_shd[cfg_chan] <= cfg_div;
        end else begin
          div_shd[cfg_chan] <= cfg_div;
          pend              <= 1'b1;
          pend_chan         <= cfg_chan;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_enable_scheduler.sv
// Directed self-checking bench for clock_enable_scheduler (NCHAN=4, DIVW=8).
// Define CLKSCHED_PHASE_EN for both files to exercise the phase output.
module tb_clock_enable_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic [3:0] chan_en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_chan;
  logic [7:0] cfg_div;
  logic       running;
  logic [3:0] tick;
`ifdef CLKSCHED_PHASE_EN
  logic [3:0] phase;
`endif

  int checks = 0;
  int errors = 0;

  clock_enable_scheduler #(.NCHAN(4), .DIVW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .chan_en   (chan_en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .running   (running),
    .tick      (tick)
`ifdef CLKSCHED_PHASE_EN
    ,
    .phase     (phase)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write_idle(input logic [1:0] ch, input logic [7:0] d);
    cfg_valid = 1'b1;
    cfg_chan  = ch;
    cfg_div   = d;
    step();
    cfg_valid = 1'b0;
  endtask

  // Leaves the bench just after edge E+1 (first RUN cycle).
  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL align_running: got %b expected 0", running);
    end
    step();
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL run_running: got %b expected 1", running);
    end
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (running !== 1'b0 || tick !== 4'b0000) begin
      errors++;
      $display("FAIL stop_outputs: got running=%b tick=%b expected 0 0000", running, tick);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    chan_en   = 4'hF;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_div   = '0;
    step();
    step();
    checks++;
    if (running !== 1'b0 || tick !== 4'b0000 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got running=%b tick=%b ready=%b expected 0 0000 1",
               running, tick, cfg_ready);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic_periods();
    logic [63:0] obs [4];
    logic [63:0] exp_v [4];
    int d [4];
    d[0] = 0; d[1] = 1; d[2] = 3; d[3] = 7;
    for (int c = 0; c < 4; c++) cfg_write_idle(2'(c), 8'(d[c]));
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_write_ready: got %b expected 1", cfg_ready);
    end
    do_start();
    for (int k = 2; k < 66; k++) begin
      step();
      for (int c = 0; c < 4; c++) begin
        obs[c][k-2]   = tick[c];
        exp_v[c][k-2] = ((k - 2 - d[c]) >= 0) && (((k - 2 - d[c]) % (d[c] + 1)) == 0);
      end
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (obs[c] !== exp_v[c]) begin
        errors++;
        $display("FAIL basic_ch%0d: got %h expected %h", c, obs[c], exp_v[c]);
      end
    end
    do_stop();
  endtask

  // ch1 at D=3; D=5 written mid-period, then D=2 held while cfg_ready is low.
  task automatic test_live_reprogram();
    logic [20:0] obs;
    logic [20:0] exp_v;
    obs   = '0;
    exp_v = '0;
    exp_v[5] = 1'b1; exp_v[9] = 1'b1; exp_v[15] = 1'b1; exp_v[18] = 1'b1;
    cfg_write_idle(2'd1, 8'd3);
    do_start();
    for (int k = 2; k <= 20; k++) begin
      step();
      obs[k] = tick[1];
      if (k == 7 || k == 8 || k == 9 || k == 10 || k == 15) begin
        checks++;
        if (cfg_ready !== ((k == 9 || k == 15) ? 1'b1 : 1'b0)) begin
          errors++;
          $display("FAIL live_ready_e%0d: got %b expected %b", k, cfg_ready,
                   (k == 9 || k == 15) ? 1'b1 : 1'b0);
        end
      end
      if (k == 6) begin
        cfg_valid = 1'b1;
        cfg_chan  = 2'd1;
        cfg_div   = 8'd5;
      end
      if (k == 7) cfg_div = 8'd2;
      if (k == 10) cfg_valid = 1'b0;
    end
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL live_ticks_ch1: got %b expected %b", obs, exp_v);
    end
    do_stop();
  endtask

  task automatic test_stop_pending();
    logic [9:0] obs;
    logic [9:0] exp_v;
    obs = '0;
    exp_v = 10'b10_1010_1000;
    cfg_write_idle(2'd2, 8'd3);
    do_start();
    cfg_valid = 1'b1;
    cfg_chan  = 2'd2;
    cfg_div   = 8'd1;
    step();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL pend_ready_low: got %b expected 0", cfg_ready);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (running !== 1'b0 || tick !== 4'b0000 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL stop_pend_outputs: got running=%b tick=%b ready=%b expected 0 0000 1",
               running, tick, cfg_ready);
    end
    do_start();
    for (int k = 2; k <= 9; k++) begin
      step();
      obs[k] = tick[2];
    end
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL restart_ch2: got %b expected %b", obs, exp_v);
    end
    do_stop();
  endtask

  task automatic test_masking();
    logic [17:0] obs [4];
    logic [17:0] exp_v [4];
    for (int c = 0; c < 4; c++) begin
      cfg_write_idle(2'(c), 8'd1);
      obs[c]   = '0;
      exp_v[c] = '0;
    end
    chan_en = 4'b0101;
    do_start();
    for (int k = 2; k <= 17; k++) begin
      step();
      for (int c = 0; c < 4; c++) begin
        obs[c][k] = tick[c];
        exp_v[c][k] = (k >= 3) && (k % 2 == 1) &&
                      (c == 0 || c == 2 || (c == 1 && k >= 10));
      end
      if (k == 9) chan_en = 4'b0111;
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (obs[c] !== exp_v[c]) begin
        errors++;
        $display("FAIL mask_ch%0d: got %b expected %b", c, obs[c], exp_v[c]);
      end
    end
    chan_en = 4'hF;
    do_stop();
  endtask

  task automatic test_async_reset();
    int bad;
    bad = 0;
    for (int c = 0; c < 4; c++) cfg_write_idle(2'(c), 8'd3);
    do_start();
    cfg_valid = 1'b1;
    cfg_chan  = 2'd2;
    cfg_div   = 8'd5;
    step();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_pend_set: got %b expected 0", cfg_ready);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (running !== 1'b0 || tick !== 4'b0000 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_outputs: got running=%b tick=%b ready=%b expected 0 0000 1",
               running, tick, cfg_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    do_start();
    for (int k = 2; k <= 9; k++) begin
      step();
      if (tick !== 4'hF) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL post_reset_ticks: got %0d non-1111 cycles expected 0", bad);
    end
    do_stop();
  endtask

`ifdef CLKSCHED_PHASE_EN
  task automatic test_phase();
    logic [13:0] obs;
    logic [13:0] exp_v;
    obs   = '0;
    exp_v = '0;
    cfg_write_idle(2'd0, 8'd1);
    do_start();
    checks++;
    if (phase[0] !== 1'b0) begin
      errors++;
      $display("FAIL phase_after_align: got %b expected 0", phase[0]);
    end
    for (int k = 2; k <= 13; k++) begin
      step();
      obs[k]   = phase[0];
      exp_v[k] = (k >= 3) ? 1'(((k - 1) / 2) % 2) : 1'b0;
    end
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL phase_ch0: got %b expected %b", obs, exp_v);
    end
    do_stop();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_periods();
    test_live_reprogram();
    test_stop_pending();
    test_masking();
    test_async_reset();
`ifdef CLKSCHED_PHASE_EN
    test_phase();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
